// File: rtl/mmio_arb_pkg.sv
// mmio_arb_pkg: shared types and default widths for the two-master MMIO arbiter.
package mmio_arb_pkg;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with last-served pointer.
// Optional grant lock enabled by defining MMIO_ARB_LOCK_EN: a winner that
// holds its lock during RESP keeps priority for the next grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic [1:0] lock_i,
    input  logic       grant_en_i,
    input  logic       resp_i,
    output logic       gnt_o
);

    logic last_q, last_d;

`ifdef MMIO_ARB_LOCK_EN
    logic lock_q, lock_d;
`else
    logic unused_lock;
    assign unused_lock = ^{lock_i, resp_i};
`endif

    // Winner select: a lone requester wins, contention goes to the master not served last
    always_comb begin
        gnt_o = ~last_q;
        if (req_i == 2'b01)
            gnt_o = 1'b0;
        else if (req_i == 2'b10)
            gnt_o = 1'b1;
`ifdef MMIO_ARB_LOCK_EN
        else if (lock_q)
            gnt_o = last_q;
`endif
    end

    // Pointer moves to whoever is granted
    always_comb begin
        last_d = last_q;
        if (grant_en_i && |req_i)
            last_d = gnt_o;
    end

`ifdef MMIO_ARB_LOCK_EN
    // Lock is taken from the owner during RESP and consumed by the next grant
    always_comb begin
        lock_d = lock_q;
        if (resp_i)
            lock_d = lock_i[last_q];
        else if (grant_en_i && |req_i)
            lock_d = 1'b0;
    end

    // Lock state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`endif

    // Pointer register; reset points at master 1 so master 0 wins first contention
    always_ff @(posedge clk or posedge reset) begin
        if (reset) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/mmio_arbiter.sv
// mmio_arbiter: two masters share one MMIO slot bus, one transaction per
// IDLE -> ISSUE -> RESP sweep. Define MMIO_ARB_LOCK_EN to honour mN_lock.
module mmio_arbiter
    import mmio_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_cs,
    input  logic              m0_wr,
    input  logic              m0_rd,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wr_data,
    input  logic              m0_lock,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rd_data,
    input  logic              m1_cs,
    input  logic              m1_wr,
    input  logic              m1_rd,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wr_data,
    input  logic              m1_lock,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rd_data,
    output logic              mmio_cs,
    output logic              mmio_wr,
    output logic              mmio_rd,
    output logic [ADDR_W-1:0] mmio_addr,
    output logic [DATA_W-1:0] mmio_wr_data,
    input  logic [DATA_W-1:0] mmio_rd_data
);

    state_e state_q, state_d;

    logic [1:0]        req;
    logic              gnt;
    logic              win_q;
    logic              wr_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;

    logic              sel_wr, sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req = {m1_cs & (m1_wr | m1_rd), m0_cs & (m0_wr | m0_rd)};

    assign sel_wr    = gnt ? m1_wr      : m0_wr;
    assign sel_rd    = gnt ? m1_rd      : m0_rd;
    assign sel_addr  = gnt ? m1_addr    : m0_addr;
    assign sel_wdata = gnt ? m1_wr_data : m0_wr_data;

    rr_arbiter2 u_arb (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req),
        .lock_i     ({m1_lock, m0_lock}),
        .grant_en_i (state_q == IDLE),
        .resp_i     (state_q == RESP),
        .gnt_o      (gnt)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: wait for a request, then one ISSUE and one RESP cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|req) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command capture in IDLE (write wins over read) and read-data capture in ISSUE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_q   <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && |req) begin
                win_q   <= gnt;
                wr_q    <= sel_wr;
                rd_q    <= sel_rd & ~sel_wr;
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
            end
            if (state_q == ISSUE)
                rdata_q <= rd_q ? mmio_rd_data : '0;
        end
    end

    // Outputs: bus driven only in ISSUE, ack and data only to the winner in RESP
    always_comb begin
        mmio_cs      = 1'b0;
        mmio_wr      = 1'b0;
        mmio_rd      = 1'b0;
        mmio_addr    = '0;
        mmio_wr_data = '0;
        m0_ack       = 1'b0;
        m1_ack       = 1'b0;
        m0_rd_data   = '0;
        m1_rd_data   = '0;
        case (state_q)
            ISSUE: begin
                mmio_cs      = 1'b1;
                mmio_wr      = wr_q;
                mmio_rd      = rd_q;
                mmio_addr    = addr_q;
                mmio_wr_data = wdata_q;
            end
            RESP: begin
                if (win_q) begin
                    m1_ack     = 1'b1;
                    m1_rd_data = rdata_q;
                end else begin
                    m0_ack     = 1'b1;
                    m0_rd_data = rdata_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mmio_arbiter.sv
// tb_mmio_arbiter: directed scoreboard bench. Tests push expected bus
// commands and acks into queues; one monitor pops and compares them.
module tb_mmio_arbiter;

    typedef struct packed {
        logic        m;
        logic        wr;
        logic        rd;
        logic [20:0] addr;
        logic [31:0] wd;
    } bus_t;

    typedef struct packed {
        logic        m;
        logic [31:0] d;
    } ack_t;

    logic        clk, reset;
    logic        m0_cs, m0_wr, m0_rd, m0_lock, m0_ack;
    logic [20:0] m0_addr;
    logic [31:0] m0_wr_data, m0_rd_data;
    logic        m1_cs, m1_wr, m1_rd, m1_lock, m1_ack;
    logic [20:0] m1_addr;
    logic [31:0] m1_wr_data, m1_rd_data;
    logic        mmio_cs, mmio_wr, mmio_rd;
    logic [20:0] mmio_addr;
    logic [31:0] mmio_wr_data;
    logic [31:0] bus_rdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   bus_cyc = -10;
    logic bus_m  = 1'b0;
    bus_t bus_q[$];
    ack_t ack_q[$];
    bus_t be;
    ack_t ae;

    mmio_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_rd(m0_rd), .m0_addr(m0_addr),
        .m0_wr_data(m0_wr_data), .m0_lock(m0_lock), .m0_ack(m0_ack), .m0_rd_data(m0_rd_data),
        .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_rd(m1_rd), .m1_addr(m1_addr),
        .m1_wr_data(m1_wr_data), .m1_lock(m1_lock), .m1_ack(m1_ack), .m1_rd_data(m1_rd_data),
        .mmio_cs(mmio_cs), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
        .mmio_wr_data(mmio_wr_data), .mmio_rd_data(bus_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: bus commands and acks against the expected queues
    always @(negedge clk) begin
        if (mmio_cs) begin
            checks++;
            if (bus_q.size() == 0) begin
                errors++;
                $display("FAIL bus_unexpected: mmio_cs with nothing expected (addr=%h)", mmio_addr);
            end else begin
                be = bus_q.pop_front();
                bus_cyc = cyc;
                bus_m = be.m;
                if (mmio_wr !== be.wr || mmio_rd !== be.rd || mmio_addr !== be.addr || mmio_wr_data !== be.wd) begin
                    errors++;
                    $display("FAIL bus_cmd: got wr=%0b rd=%0b addr=%h wd=%h, want wr=%0b rd=%0b addr=%h wd=%h",
                             mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, be.wr, be.rd, be.addr, be.wd);
                end
            end
        end else begin
            checks++;
            if ({mmio_wr, mmio_rd, mmio_addr, mmio_wr_data} !== '0) begin
                errors++;
                $display("FAIL bus_idle: wr=%0b rd=%0b addr=%h wd=%h, want all 0",
                         mmio_wr, mmio_rd, mmio_addr, mmio_wr_data);
            end
        end

        if (m0_ack || m1_ack) begin
            checks++;
            if (m0_ack && m1_ack) begin
                errors++;
                $display("FAIL ack_both: m0_ack=1 m1_ack=1, want one");
            end else if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: m0_ack=%0b m1_ack=%0b with nothing expected", m0_ack, m1_ack);
            end else begin
                ae = ack_q.pop_front();
                if (m1_ack !== ae.m || (m1_ack ? m1_rd_data : m0_rd_data) !== ae.d ||
                    (m1_ack ? m0_rd_data : m1_rd_data) !== '0) begin
                    errors++;
                    $display("FAIL ack_resp: got master=%0d data=%h other=%h, want master=%0d data=%h other=0",
                             m1_ack, m1_ack ? m1_rd_data : m0_rd_data, m1_ack ? m0_rd_data : m1_rd_data, ae.m, ae.d);
                end
                checks++;
                if (cyc != bus_cyc + 1 || bus_m !== m1_ack) begin
                    errors++;
                    $display("FAIL ack_latency: ack at cycle %0d master %0d, want cycle %0d master %0d",
                             cyc, m1_ack, bus_cyc + 1, bus_m);
                end
            end
        end else begin
            checks++;
            if (m0_rd_data !== '0 || m1_rd_data !== '0) begin
                errors++;
                $display("FAIL idle_rd_data: m0=%h m1=%h, want 0", m0_rd_data, m1_rd_data);
            end
        end
    end

    task automatic set_m(input int n, input logic cs, input logic wr, input logic rd,
                         input logic [20:0] a, input logic [31:0] d, input logic lk);
        if (n == 0) begin
            m0_cs = cs; m0_wr = wr; m0_rd = rd; m0_addr = a; m0_wr_data = d; m0_lock = lk;
        end else begin
            m1_cs = cs; m1_wr = wr; m1_rd = rd; m1_addr = a; m1_wr_data = d; m1_lock = lk;
        end
    endtask

    task automatic drop_m(input int n);
        set_m(n, 1'b0, 1'b0, 1'b0, 21'h0, 32'h0, 1'b0);
    endtask

    task automatic push_bus(input logic m, input logic wr, input logic rd,
                            input logic [20:0] a, input logic [31:0] d);
        bus_t e;
        e.m = m; e.wr = wr; e.rd = rd; e.addr = a; e.wd = d;
        bus_q.push_back(e);
    endtask

    task automatic push_ack(input logic m, input logic [31:0] d);
        ack_t e;
        e.m = m; e.d = d;
        ack_q.push_back(e);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if ({mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data} !== '0) begin
            errors++;
            $display("FAIL %s: cs=%0b wr=%0b rd=%0b addr=%h wd=%h ack0=%0b ack1=%0b rd0=%h rd1=%h, want all 0",
                     name, mmio_cs, mmio_wr, mmio_rd, mmio_addr, mmio_wr_data, m0_ack, m1_ack, m0_rd_data, m1_rd_data);
        end
    endtask

    // Wait for any ack; returns who acked and how many negedges it took
    task automatic wait_ack(output int who, output int n);
        who = -1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                who = m1_ack ? 1 : 0;
                n = i;
                break;
            end
        end
        if (who < 0) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: no ack within 20 cycles, want one");
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        drop_m(0);
        drop_m(1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int who, n, n1;
        bit done, seen;
        reset = 1'b1;
        bus_rdata = 32'h0;
        drop_m(0);
        drop_m(1);
        repeat (3) @(negedge clk);
        chk_zero("reset_state");
        reset = 1'b0;

        // Single read from master 0
        @(negedge clk);
        bus_rdata = 32'hDEADBEEF;
        push_bus(0, 0, 1, 21'h000C0, 32'h0);
        push_ack(0, 32'hDEADBEEF);
        set_m(0, 1, 0, 1, 21'h000C0, 32'h0, 0);
        wait_ack(who, n);
        drop_m(0);
        chk("read_who", who, 0);
        chk("read_latency", n, 2);

        // Simultaneous writes right after reset: m0 then m1, 3 cycles apart
        apply_reset();
        push_bus(0, 1, 0, 21'h00100, 32'h11110000);
        push_bus(1, 1, 0, 21'h00200, 32'h22220000);
        push_ack(0, 32'h0);
        push_ack(1, 32'h0);
        set_m(0, 1, 1, 0, 21'h00100, 32'h11110000, 0);
        set_m(1, 1, 1, 0, 21'h00200, 32'h22220000, 0);
        wait_ack(who, n);
        drop_m(0);
        chk("dual_first", who, 0);
        wait_ack(who, n);
        drop_m(1);
        chk("dual_second", who, 1);
        chk("dual_ack_gap", n, 3);

        // Write and read strobes together: write wins, no read data
        @(negedge clk);
        push_bus(0, 1, 0, 21'h00044, 32'h55);
        push_ack(0, 32'h0);
        set_m(0, 1, 1, 1, 21'h00044, 32'h55, 0);
        wait_ack(who, n);
        drop_m(0);
        chk("wr_rd_who", who, 0);
        chk("wr_rd_latency", n, 2);

        // Lone master 1 read, then continuous contention alternates 0,1,0,1,0,1
        @(negedge clk);
        bus_rdata = 32'h12345678;
        push_bus(1, 0, 1, 21'h00300, 32'h0);
        push_ack(1, 32'h12345678);
        set_m(1, 1, 0, 1, 21'h00300, 32'h0, 0);
        wait_ack(who, n);
        drop_m(1);
        chk("lone_m1_who", who, 1);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_bus(0, 1, 0, 21'h00010, 32'hA0);
            else            push_bus(1, 1, 0, 21'h00020, 32'hB0);
            push_ack(i % 2, 32'h0);
        end
        set_m(0, 1, 1, 0, 21'h00010, 32'hA0, 0);
        set_m(1, 1, 1, 0, 21'h00020, 32'hB0, 0);
        for (int i = 0; i < 6; i++) begin
            wait_ack(who, n);
            chk($sformatf("rr_grant%0d", i), who, i % 2);
        end
        drop_m(0);
        drop_m(1);

        // Reset during ISSUE: abandoned, outputs clear at once, m0 wins next contention
        @(negedge clk);
        push_bus(0, 1, 0, 21'h00080, 32'h8);
        push_ack(0, 32'h0);
        set_m(0, 1, 1, 0, 21'h00080, 32'h8, 0);
        wait_ack(who, n);
        drop_m(0);
        @(negedge clk);
        push_bus(0, 0, 1, 21'h00050, 32'h0);
        set_m(0, 1, 0, 1, 21'h00050, 32'h0, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mmio_cs) begin
                seen = 1;
                break;
            end
        end
        chk("issue_seen", int'(seen), 1);
        #1 reset = 1'b1;
        #1 chk_zero("async_reset");
        drop_m(0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        push_bus(0, 1, 0, 21'h00060, 32'h6);
        push_bus(1, 1, 0, 21'h00070, 32'h7);
        push_ack(0, 32'h0);
        push_ack(1, 32'h0);
        set_m(0, 1, 1, 0, 21'h00060, 32'h6, 0);
        set_m(1, 1, 1, 0, 21'h00070, 32'h7, 0);
        wait_ack(who, n);
        drop_m(0);
        chk("post_reset_first", who, 0);
        wait_ack(who, n);
        drop_m(1);
        chk("post_reset_second", who, 1);

        // Lock: m1 holds lock over 3 requests while m0 requests continuously
        @(negedge clk);
        push_bus(0, 1, 0, 21'h00080, 32'h8);
        push_ack(0, 32'h0);
        set_m(0, 1, 1, 0, 21'h00080, 32'h8, 0);
        wait_ack(who, n);
        drop_m(0);
        @(negedge clk);
`ifdef MMIO_ARB_LOCK_EN
        for (int i = 0; i < 3; i++) begin
            push_bus(1, 1, 0, 21'h00090, 32'h9);
            push_ack(1, 32'h0);
        end
        push_bus(0, 1, 0, 21'h000A0, 32'hA);
        push_ack(0, 32'h0);
`else
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push_bus(1, 1, 0, 21'h00090, 32'h9);
            else            push_bus(0, 1, 0, 21'h000A0, 32'hA);
            push_ack(~i[0], 32'h0);
        end
`endif
        set_m(0, 1, 1, 0, 21'h000A0, 32'hA, 0);
        set_m(1, 1, 1, 0, 21'h00090, 32'h9, 1);
        n1 = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            wait_ack(who, n);
            if (who == 1) begin
                n1++;
                if (n1 == 3) drop_m(1);
            end else if (who == 0 && n1 == 3) begin
                drop_m(0);
                done = 1;
            end else if (who < 0) begin
                done = 1;
            end
        end
        drop_m(0);
        drop_m(1);
        chk("lock_m1_count", n1, 3);

        repeat (3) @(negedge clk);
        checks++;
        if (bus_q.size() != 0 || ack_q.size() != 0) begin
            errors++;
            $display("FAIL queues_drained: bus=%0d ack=%0d left, want 0", bus_q.size(), ack_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
